// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the configurable pipeline stage register
// used between the RV32I pipeline stages.
package pipe_pkg;

  localparam int PIPE_LEGACY  = 0;
  localparam int PIPE_ELASTIC = 1;

  // addi x0, x0, 0: the canonical RV32I bubble instruction
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Bit offset of channel k in a bus of w-bit channels
  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer: catches a beat accepted while the main register
// is full and blocked downstream.
module pipe_skid_buf #(
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   RST_DATA = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] load_data,
  output logic          skid_valid,
  output logic [DW-1:0] skid_data
);

  logic          valid_d, valid_q;
  logic [DW-1:0] data_d, data_q;

  // load and drain never coincide: upstream is refused while the entry is full
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = RST_DATA;
    end else if (drain) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign skid_valid = valid_q;
  assign skid_data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-channel pipeline stage register: legacy stall/flush mode or elastic
// valid/ready mode with a skid buffer, plus a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int           W                = 32,
  parameter int           CH               = 1,
  parameter int           ELASTIC          = PIPE_LEGACY,
  parameter int           FLUSH_OVER_STALL = 0,
  parameter logic [W-1:0] FLUSH_VAL        = '0,
  parameter int           CNT_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CH*W-1:0]   in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CH*W-1:0]   out_data,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DW = CH * W;

  function automatic logic [DW-1:0] flush_bus();
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < CH; k++) b[ch_lsb(k, W) +: W] = FLUSH_VAL;
    return b;
  endfunction

  localparam logic [DW-1:0]    FLUSH_BUS = flush_bus();
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_d, out_valid_q;
  logic [DW-1:0]    data_d, data_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             held;

  generate
    if (ELASTIC == PIPE_ELASTIC) begin : g_elastic
      // Handshake: a beat moves upstream when in_valid & in_ready and
      // downstream when out_valid & out_ready & ~stall; in_ready is a flop.
      logic          dr;
      logic          up_xfer;
      logic          skid_load;
      logic          skid_drain;
      logic          skid_valid;
      logic [DW-1:0] skid_data;

      assign dr         = out_ready & ~stall;
      assign up_xfer    = in_valid & ~skid_valid;
      assign skid_load  = up_xfer & out_valid_q & ~dr;
      assign skid_drain = skid_valid & dr;

      pipe_skid_buf #(
        .DW       (DW),
        .RST_DATA (FLUSH_BUS)
      ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (skid_load),
        .drain      (skid_drain),
        .load_data  (in_data),
        .skid_valid (skid_valid),
        .skid_data  (skid_data)
      );

      // The skid entry is older than anything upstream, so it refills first
      always_comb begin
        valid_d = out_valid_q;
        data_d  = data_q;
        if (flush) begin
          valid_d = 1'b0;
          data_d  = FLUSH_BUS;
        end else if (!out_valid_q || dr) begin
          if (skid_valid) begin
            valid_d = 1'b1;
            data_d  = skid_data;
          end else if (up_xfer) begin
            valid_d = 1'b1;
            data_d  = in_data;
          end else begin
            valid_d = 1'b0;
          end
        end
      end

      assign held     = out_valid_q & ~dr;
      assign in_ready = ~skid_valid;
    end else begin : g_legacy
      localparam logic FLUSH_WINS = (FLUSH_OVER_STALL != 0);
      logic hold;
      logic unused_out_ready;

      assign hold             = stall & ~(FLUSH_WINS & flush);
      assign unused_out_ready = out_ready;

      always_comb begin
        valid_d = in_valid;
        data_d  = in_data;
        if (hold) begin
          valid_d = out_valid_q;
          data_d  = data_q;
        end else if (flush) begin
          valid_d = 1'b0;
          data_d  = FLUSH_BUS;
        end
      end

      assign held     = out_valid_q & stall;
      assign in_ready = 1'b1;
    end
  endgenerate

  // Counts cycles a valid beat sat in the stage without advancing
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (held && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_q      <= FLUSH_BUS;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= valid_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two legacy instances (flush masked / flush wins)
// and one elastic instance, each compared every cycle against a reference model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // legacy stimulus, shared by both legacy instances
  logic        l_stall, l_flush, l_in_valid, l_out_ready, l_cnt_clr;
  logic [63:0] l_in_data;
  logic        l0_in_ready, l0_out_valid, l1_in_ready, l1_out_valid;
  logic [63:0] l0_out_data, l1_out_data;
  logic [3:0]  l0_cnt;
  logic [15:0] l1_cnt;

  // elastic stimulus
  logic        e_stall, e_flush, e_in_valid, e_out_ready, e_cnt_clr;
  logic [63:0] e_in_data;
  logic        e_in_ready, e_out_valid;
  logic [63:0] e_out_data;
  logic [15:0] e_cnt;

  localparam logic [63:0] E_FLUSH = 64'h00000013_00000013;

  pipe_stage_reg #(.W(32), .CH(2), .ELASTIC(0), .FLUSH_OVER_STALL(0),
                   .FLUSH_VAL(32'h0), .CNT_W(4)) dut_l0 (
    .clk(clk), .rst(rst), .stall(l_stall), .flush(l_flush),
    .in_valid(l_in_valid), .in_data(l_in_data), .in_ready(l0_in_ready),
    .out_valid(l0_out_valid), .out_data(l0_out_data), .out_ready(l_out_ready),
    .cnt_clr(l_cnt_clr), .stall_cnt(l0_cnt));

  pipe_stage_reg #(.W(32), .CH(2), .ELASTIC(0), .FLUSH_OVER_STALL(1),
                   .FLUSH_VAL(32'h0), .CNT_W(16)) dut_l1 (
    .clk(clk), .rst(rst), .stall(l_stall), .flush(l_flush),
    .in_valid(l_in_valid), .in_data(l_in_data), .in_ready(l1_in_ready),
    .out_valid(l1_out_valid), .out_data(l1_out_data), .out_ready(l_out_ready),
    .cnt_clr(l_cnt_clr), .stall_cnt(l1_cnt));

  pipe_stage_reg #(.W(32), .CH(2), .ELASTIC(1), .FLUSH_OVER_STALL(0),
                   .FLUSH_VAL(32'h13), .CNT_W(16)) dut_e (
    .clk(clk), .rst(rst), .stall(e_stall), .flush(e_flush),
    .in_valid(e_in_valid), .in_data(e_in_data), .in_ready(e_in_ready),
    .out_valid(e_out_valid), .out_data(e_out_data), .out_ready(e_out_ready),
    .cnt_clr(e_cnt_clr), .stall_cnt(e_cnt));

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference models ----------------
  bit          m0_v, m1_v;
  logic [63:0] m0_d, m1_d;
  int          m0_cnt, m1_cnt;
  logic [63:0] exp_q[$];     // beats held by the elastic stage, oldest first
  int          me_cnt;
  bit          me_flushed;   // main data known to be the flush value

  always @(posedge clk) begin
    bit dr, acc;
    if (rst) begin
      m0_v = 0; m1_v = 0; m0_d = '0; m1_d = '0; m0_cnt = 0; m1_cnt = 0;
      exp_q.delete(); me_cnt = 0; me_flushed = 1;
    end else begin
      // legacy: counters use the valid bit before this edge
      if (l_cnt_clr) begin
        m0_cnt = 0; m1_cnt = 0;
      end else begin
        if (m0_v && l_stall && m0_cnt < 15) m0_cnt++;
        if (m1_v && l_stall && m1_cnt < 65535) m1_cnt++;
      end
      if (!l_stall) begin
        if (l_flush) begin m0_v = 0; m0_d = '0; end
        else begin m0_v = l_in_valid; m0_d = l_in_data; end
      end
      if (!l_stall || l_flush) begin
        if (l_flush) begin m1_v = 0; m1_d = '0; end
        else begin m1_v = l_in_valid; m1_d = l_in_data; end
      end
      // elastic: a FIFO of at most two beats
      dr = e_out_ready && !e_stall;
      if (e_cnt_clr) me_cnt = 0;
      else if (exp_q.size() > 0 && !dr && me_cnt < 65535) me_cnt++;
      if (e_flush) begin
        exp_q.delete();
        me_flushed = 1;
      end else begin
        acc = e_in_valid && (exp_q.size() < 2);
        if (exp_q.size() > 0 && dr) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back(e_in_data);
          me_flushed = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("l0_valid", 64'(l0_out_valid), 64'(m0_v));
      chk("l0_data", l0_out_data, m0_d);
      chk("l0_cnt", 64'(l0_cnt), 64'(m0_cnt));
      chk("l0_in_ready", 64'(l0_in_ready), 64'd1);
      chk("l1_valid", 64'(l1_out_valid), 64'(m1_v));
      chk("l1_data", l1_out_data, m1_d);
      chk("l1_cnt", 64'(l1_cnt), 64'(m1_cnt));
      chk("e_valid", 64'(e_out_valid), 64'(exp_q.size() > 0));
      chk("e_in_ready", 64'(e_in_ready), 64'(exp_q.size() < 2));
      chk("e_cnt", 64'(e_cnt), 64'(me_cnt));
      if (exp_q.size() > 0) chk("e_data", e_out_data, exp_q[0]);
      else if (me_flushed) chk("e_flush_data", e_out_data, E_FLUSH);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    l_stall = 0; l_flush = 0; l_in_valid = 0; l_out_ready = 1; l_cnt_clr = 0; l_in_data = '0;
    e_stall = 0; e_flush = 0; e_in_valid = 0; e_out_ready = 1; e_cnt_clr = 0; e_in_data = '0;
  endtask

  initial begin
    // reset while stalled with valid input present
    rst = 1;
    idle_all();
    l_stall = 1; l_in_valid = 1; l_in_data = 64'hDEAD_BEEF_0BAD_F00D;
    e_stall = 1; e_in_valid = 1; e_in_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    tick();
    chk("rst_l0_valid", 64'(l0_out_valid), 64'd0);
    chk("rst_l0_data", l0_out_data, 64'd0);
    chk("rst_l0_cnt", 64'(l0_cnt), 64'd0);
    chk("rst_e_valid", 64'(e_out_valid), 64'd0);
    chk("rst_e_data", e_out_data, E_FLUSH);
    chk("rst_e_in_ready", 64'(e_in_ready), 64'd1);
    rst = 0;
    idle_all();
    chk_en = 1;

    // legacy: load {1,2}, stall three cycles with changing input
    l_in_valid = 1; l_in_data = {32'h1, 32'h2};
    tick();
    chk("lg_load_data", l0_out_data, 64'h00000001_00000002);
    chk("lg_load_valid", 64'(l0_out_valid), 64'd1);
    l_stall = 1;
    for (int i = 0; i < 3; i++) begin
      l_in_data = {$urandom(), $urandom()};
      tick();
    end
    chk("lg_stall_data", l0_out_data, 64'h00000001_00000002);
    chk("lg_stall_cnt0", 64'(l0_cnt), 64'd3);
    chk("lg_stall_cnt1", 64'(l1_cnt), 64'd3);
    l_flush = 1;
    tick();
    chk("lg_masked_flush", l0_out_data, 64'h00000001_00000002);
    chk("lg_masked_valid", 64'(l0_out_valid), 64'd1);
    chk("lg_flush_wins_data", l1_out_data, 64'd0);
    chk("lg_flush_wins_valid", 64'(l1_out_valid), 64'd0);
    l_flush = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("lg_saturate", 64'(l0_cnt), 64'd15);
    l_cnt_clr = 1;
    tick();
    chk("lg_cnt_clr", 64'(l0_cnt), 64'd0);
    idle_all();
    tick();

    // elastic backpressure: A, B, C
    e_in_valid = 1; e_in_data = 64'hA; e_out_ready = 1;
    tick();
    e_in_data = 64'hB; e_out_ready = 0;
    tick();
    chk("el_bp_out_a", e_out_data, 64'hA);
    chk("el_bp_in_ready", 64'(e_in_ready), 64'd0);
    e_in_data = 64'hC;
    tick();
    chk("el_bp_hold_a", e_out_data, 64'hA);
    chk("el_bp_cnt", 64'(e_cnt), 64'd2);
    e_out_ready = 1;
    tick();
    chk("el_out_b", e_out_data, 64'hB);
    chk("el_ready_back", 64'(e_in_ready), 64'd1);
    tick();
    chk("el_out_c", e_out_data, 64'hC);
    e_in_valid = 0;
    tick();
    chk("el_drained", 64'(e_out_valid), 64'd0);

    // elastic flush with the skid entry full
    e_in_valid = 1; e_in_data = 64'h11; e_out_ready = 0;
    tick();
    e_in_data = 64'h12;
    tick();
    chk("el_skid_full", 64'(e_in_ready), 64'd0);
    e_in_valid = 0; e_flush = 1;
    tick();
    chk("el_flush_valid", 64'(e_out_valid), 64'd0);
    chk("el_flush_ready", 64'(e_in_ready), 64'd1);
    chk("el_flush_data", e_out_data, E_FLUSH);
    e_flush = 0; e_in_valid = 1; e_in_data = 64'hD; e_out_ready = 1;
    tick();
    chk("el_after_flush_d", e_out_data, 64'hD);
    chk("el_after_flush_v", 64'(e_out_valid), 64'd1);
    e_in_valid = 0; e_cnt_clr = 1;
    tick();
    e_cnt_clr = 0;

    // elastic full throughput, 16 beats
    e_in_valid = 1; e_out_ready = 1;
    for (int k = 0; k < 16; k++) begin
      e_in_data = 64'(k + 100);
      tick();
      chk("el_tput_data", e_out_data, 64'(k + 100));
      chk("el_tput_valid", 64'(e_out_valid), 64'd1);
    end
    e_in_valid = 0;
    tick();
    chk("el_tput_cnt", 64'(e_cnt), 64'd0);

    // randomized traffic on all instances
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      l_stall     = ($urandom_range(0, 3) == 0);
      l_flush     = ($urandom_range(0, 15) == 0);
      l_in_valid  = ($urandom_range(0, 9) < 7);
      l_in_data   = {$urandom(), $urandom()};
      l_out_ready = $urandom_range(0, 1) != 0;
      l_cnt_clr   = ($urandom_range(0, 49) == 0);
      e_stall     = ($urandom_range(0, 4) == 0);
      e_flush     = ($urandom_range(0, 24) == 0);
      e_in_valid  = ($urandom_range(0, 9) < 7);
      e_in_data   = {$urandom(), $urandom()};
      e_out_ready = ($urandom_range(0, 9) < 6);
      e_cnt_clr   = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0;
    idle_all();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, multi-channel pipeline stage register for the RV32I 5-stage core. It replaces the single 32-bit per-stage result/operand registers with one configurable block.
- Legacy mode: stall (bubble) and flush control, plus a valid bit.
- Elastic mode: valid/ready handshake with a one-entry skid buffer.
- Both modes: a saturating stall-cycle counter for performance monitoring.
Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
W, 32, data width per channel in bits
CH, 1, number of parallel channels carried by the stage
ELASTIC, 0, 0 = legacy stall/flush mode; 1 = valid/ready mode with skid buffer
FLUSH_OVER_STALL, 0, 0 = stall masks flush (legacy core behaviour); 1 = flush wins over stall
FLUSH_VAL, 0, W-bit value loaded into every channel on flush and on reset
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
stall  input  1  hold stage contents (bubble)
flush  input  1  squash stage contents
in_valid  input  1  upstream data valid
in_data  input  CH*W  upstream data; channel k = bits [k*W +: W]
in_ready  output  1  stage can accept data (tied 1 when ELASTIC=0)
out_valid  output  1  stage holds valid data
out_data  output  CH*W  registered stage data
out_ready  input  1  downstream accepts (ignored when ELASTIC=0)
cnt_clr  input  1  synchronous clear of stall_cnt
stall_cnt  output  CNT_W  saturating count of held-valid cycles

Behaviour:
Reset (rst=1 at posedge):
- out_valid=0; every out_data channel = FLUSH_VAL.
- Skid buffer empty and its data = FLUSH_VAL.
- stall_cnt=0.
- rst overrides all other inputs.

Legacy mode (ELASTIC=0), one-cycle latency, no combinational in-to-out path:
- stall=1, FLUSH_OVER_STALL=0: hold data and valid; flush ignored.
- stall=1 and flush=1, FLUSH_OVER_STALL=1: flush.
- flush (not masked): out_data=FLUSH_VAL on all channels, out_valid=0.
- Otherwise: out_data<=in_data, out_valid<=in_valid.
- in_ready is constant 1; the skid buffer is not instantiated.

Elastic mode (ELASTIC=1):
- Effective downstream ready: dr = out_ready & ~stall.
- in_ready = ~skid_valid, registered (no combinational path from out_ready to in_ready).
- Upstream transfer occurs when in_valid & in_ready.
- Main register loads when ~out_valid | dr. Source priority: skid entry if skid_valid, else in_data if an upstream transfer occurs, else out_valid<=0.
- Upstream transfer while out_valid & ~dr: data goes to the skid entry; skid_valid<=1.
- Skid full and dr=1: skid moves to main; skid_valid<=0; a simultaneous upstream transfer is impossible (in_ready=0).
- flush: main and skid valids <=0 and data <=FLUSH_VAL, same cycle. Flush beats stall and handshake regardless of FLUSH_OVER_STALL.
- Ordering is strictly FIFO; no beat is dropped or duplicated; throughput is 1 beat/cycle when out_ready=1.

stall_cnt:
- Increments when out_valid=1 and the stage did not advance this cycle:
  - legacy: stall=1;
  - elastic: dr=0.
- Saturates at 2^CNT_W-1.
- cnt_clr or rst forces 0; cnt_clr takes priority over increment.

Decomposition:
- Shared package pipe_pkg: mode constants (PIPE_LEGACY=0, PIPE_ELASTIC=1), the default RV32 NOP-bubble constant, and the channel slice helper for the k*W indexing.
- One natural sub-module: pipe_skid_buf, the one-entry buffer with its valid and data. Instantiated via generate only when ELASTIC=1.
- The counter stays inline.

Test Plan:
1. Reset: assert rst with stall=1, in_valid=1 -> out_valid=0, out_data=FLUSH_VAL on all channels, stall_cnt=0 next cycle.
2. Legacy, W=32, CH=2: in_data={0x1,0x2}, in_valid=1, then stall for 3 cycles with new inputs -> out_data stays {0x1,0x2}, stall_cnt=3; stall+flush with FLUSH_OVER_STALL=0 -> still {0x1,0x2}; FLUSH_OVER_STALL=1 -> zeros, out_valid=0.
3. Elastic backpressure: stream beats 0xA,0xB,0xC, out_ready=0 from the cycle after 0xA lands -> 0xB captured in skid, in_ready=0; release out_ready -> outputs 0xA,0xB,0xC in order, no loss or duplicates.
4. Elastic flush with skid full -> next cycle out_valid=0, in_ready=1; a following beat 0xD appears with 1-cycle latency.
5. Elastic full throughput: out_ready=1, 16 consecutive beats -> 16 outputs on consecutive cycles, stall_cnt=0.
6. Counter saturation, CNT_W=4: hold a valid beat 20 cycles -> stall_cnt=15; cnt_clr during a stall -> 0 the next cycle.
